// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered W-to-2^W one-hot decoder with auto-scan sequencer
module scan_decoder #(
  parameter int W          = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    last,
  output logic [2**W-1:0] y,
  output logic [W-1:0]    idx,
  output logic            wrap
);

  localparam int N  = 2**W;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  // Idle level of every output line; XORing a one-hot vector with it yields the final polarity.
  localparam logic [N-1:0]  INACTIVE = {N{ACTIVE_LOW != 0}};
  localparam logic [CW-1:0] CNT_MAX  = CW'(DWELL - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [W-1:0]  idx_n;
  logic          wrap_n;
  logic [N-1:0]  y_n;

  // Next channel, dwell count, wrap flag and decoded output for the coming edge.
  always_comb begin
    idx_n  = idx;
    cnt_n  = cnt;
    wrap_n = 1'b0;
    y_n    = INACTIVE;
    if (en) begin
      if (!mode) begin
        idx_n = x;
        cnt_n = '0;
      end else if (cnt == CNT_MAX) begin
        cnt_n = '0;
        // Any index at or beyond last (e.g. left over from direct mode) falls back to channel 0.
        if (idx < last) begin
          idx_n = idx + 1'b1;
        end else begin
          idx_n  = '0;
          wrap_n = 1'b1;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
      y_n = (N'(1) << idx_n) ^ INACTIVE;
    end
  end

  // All outputs are registered; disabling blanks y but keeps idx/cnt so a scan resumes in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
      y    <= INACTIVE;
    end else begin
      idx  <= idx_n;
      cnt  <= cnt_n;
      wrap <= wrap_n;
      y    <= y_n;
    end
  end

endmodule
